// File: rtl/tmr_seq_pkg.sv
// Shared definitions for timer_request_sequencer.
// Contents: Avalon interval-timer register addresses, control-register bit
// positions and the control words the sequencer writes, and the FSM state type.
// The W_CANCEL state exists only when TMR_SEQ_CANCEL_EN is defined.
package tmr_seq_pkg;

    // Timer register map (16-bit registers)
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;

    // Control register bit positions
    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    // Control words: STOP, and one-shot START with timeout interrupt enabled
    localparam logic [15:0] CTRL_WORD_STOP  = 16'(1 << CTRL_STOP);
    localparam logic [15:0] CTRL_WORD_START = 16'((1 << CTRL_START) | (1 << CTRL_ITO));
    // Writing status clears the TO flag
    localparam logic [15:0] STATUS_WORD_CLR = 16'h0000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_STOP,
        ST_W_PL,
        ST_W_PH,
        ST_W_START,
        ST_WAIT_IRQ,
        ST_W_CLR,
        ST_DONE
`ifdef TMR_SEQ_CANCEL_EN
        , ST_W_CANCEL
`endif
    } tmr_seq_state_e;

endpackage

// File: rtl/tmr_seq_rr_arbiter.sv
// Round-robin arbiter for timer_request_sequencer.
// Ports:
//   req         in   NUM_REQ  request vector
//   ptr         in   IDX_W    highest-priority index for this decision
//   grant       out  NUM_REQ  one-hot grant (zero when no request)
//   grant_idx   out  IDX_W    index of the granted requester
//   grant_valid out  1        some request is granted
// Purely combinational; the caller owns the pointer register.
module tmr_seq_rr_arbiter
    import tmr_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int unsigned slot;

    // Scan from ptr upward with wrap; the first set request wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        slot        = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot = 32'(ptr) + i;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (!grant_valid && req[slot[IDX_W-1:0]]) begin
                grant_valid                = 1'b1;
                grant_idx                  = slot[IDX_W-1:0];
                grant[slot[IDX_W-1:0]]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_request_sequencer.sv
// timer_request_sequencer: shares one Avalon interval timer among NUM_REQ
// one-shot delay requesters. A round-robin winner is latched, the timer is
// stopped, loaded with the owner's period and started; on irq the timeout is
// cleared and done[owner] pulses for one cycle.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req/req_period      level requests and per-requester 32-bit periods
//   cancel              abort owned request while waiting for irq
//   done/done_cancelled completion pulse and its "ended by cancel" qualifier
//   busy                an owner is being serviced
//   av_*                Avalon-MM master to the timer s1 slave
// Build option: define TMR_SEQ_CANCEL_EN to enable cancel handling
// (W_CANCEL state); otherwise cancel is unused and done_cancelled is 0.
// Parameter IRQ_SYNC=1 adds a 2-flop synchroniser on av_irq.
module timer_request_sequencer
    import tmr_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IRQ_SYNC = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*32-1:0]  req_period,
    input  logic [NUM_REQ-1:0]     cancel,
    output logic [NUM_REQ-1:0]     done,
    output logic                   done_cancelled,
    output logic                   busy,
    output logic [2:0]             av_address,
    output logic                   av_chipselect,
    output logic                   av_write_n,
    output logic [15:0]            av_writedata,
    input  logic                   av_waitrequest,
    input  logic                   av_irq
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    tmr_seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      owner_idx_q, owner_idx_d;
    logic [NUM_REQ-1:0]    owner_oh_q, owner_oh_d;
    logic [31:0]           period_q, period_d;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [31:0]           sel_period;
    logic                  irq_s;
    logic                  wr_active;

    // ---------------------------------------------------------------- irq
    generate
        if (IRQ_SYNC != 0) begin : g_irq_sync
            logic [1:0] sync_q, sync_d;
            always_comb sync_d = {sync_q[0], av_irq};
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= sync_d;
            end
            assign irq_s = sync_q[1];
        end else begin : g_irq_direct
            assign irq_s = av_irq;
        end
    endgenerate

    // ---------------------------------------------------------- arbitration
    tmr_seq_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req         (req),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_period = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_period = req_period[32*i +: 32];
        end
    end

`ifdef TMR_SEQ_CANCEL_EN
    logic cancelled_q, cancelled_d;
    assign done_cancelled = (state_q == ST_DONE) && cancelled_q;
`else
    logic unused_cancel;
    assign unused_cancel  = ^cancel;
    assign done_cancelled = 1'b0;
`endif

    assign busy = (state_q != ST_IDLE);

    // ----------------------------------------------------------------- FSM
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_idx_d  = owner_idx_q;
        owner_oh_d   = owner_oh_q;
        period_d     = period_q;
`ifdef TMR_SEQ_CANCEL_EN
        cancelled_d  = cancelled_q;
`endif
        wr_active    = 1'b0;
        av_address   = '0;
        av_writedata = '0;
        done         = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_idx_d = grant_idx;
                    owner_oh_d  = grant;
                    period_d    = sel_period;
`ifdef TMR_SEQ_CANCEL_EN
                    cancelled_d = 1'b0;
`endif
                    // A zero period needs no timer at all
                    state_d = (sel_period == '0) ? ST_DONE : ST_W_STOP;
                end
            end
            ST_W_STOP: begin
                wr_active    = 1'b1;
                av_address   = ADDR_CONTROL;
                av_writedata = CTRL_WORD_STOP;
                if (!av_waitrequest) state_d = ST_W_PL;
            end
            ST_W_PL: begin
                wr_active    = 1'b1;
                av_address   = ADDR_PERIODL;
                av_writedata = period_q[15:0];
                if (!av_waitrequest) state_d = ST_W_PH;
            end
            ST_W_PH: begin
                wr_active    = 1'b1;
                av_address   = ADDR_PERIODH;
                av_writedata = period_q[31:16];
                if (!av_waitrequest) state_d = ST_W_START;
            end
            ST_W_START: begin
                wr_active    = 1'b1;
                av_address   = ADDR_CONTROL;
                av_writedata = CTRL_WORD_START;
                if (!av_waitrequest) state_d = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                // irq takes priority over a same-cycle cancel
                if (irq_s) begin
                    state_d = ST_W_CLR;
                end
`ifdef TMR_SEQ_CANCEL_EN
                else if (cancel[owner_idx_q]) begin
                    cancelled_d = 1'b1;
                    state_d     = ST_W_CANCEL;
                end
`endif
            end
`ifdef TMR_SEQ_CANCEL_EN
            ST_W_CANCEL: begin
                wr_active    = 1'b1;
                av_address   = ADDR_CONTROL;
                av_writedata = CTRL_WORD_STOP;
                if (!av_waitrequest) state_d = ST_W_CLR;
            end
`endif
            ST_W_CLR: begin
                wr_active    = 1'b1;
                av_address   = ADDR_STATUS;
                av_writedata = STATUS_WORD_CLR;
                if (!av_waitrequest) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = owner_oh_q;
                ptr_d   = (owner_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign av_chipselect = wr_active;
    assign av_write_n    = ~wr_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_idx_q <= '0;
            owner_oh_q  <= '0;
            period_q    <= '0;
`ifdef TMR_SEQ_CANCEL_EN
            cancelled_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_idx_q <= owner_idx_d;
            owner_oh_q  <= owner_oh_d;
            period_q    <= period_d;
`ifdef TMR_SEQ_CANCEL_EN
            cancelled_q <= cancelled_d;
`endif
        end
    end

endmodule

// File: tb/tb_timer_request_sequencer.sv
// Directed bench for timer_request_sequencer with an Avalon write scoreboard.
module tb_timer_request_sequencer;
    import tmr_seq_pkg::*;

    localparam int unsigned N = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [N*32-1:0] req_period;
    logic [N-1:0]  cancel;
    logic [N-1:0]  done;
    logic          done_cancelled;
    logic          busy;
    logic [2:0]    av_address;
    logic          av_chipselect;
    logic          av_write_n;
    logic [15:0]   av_writedata;
    logic          av_waitrequest;
    logic          av_irq;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    always #5 clk = ~clk;

    timer_request_sequencer #(
        .NUM_REQ  (N),
        .IRQ_SYNC (0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_period     (req_period),
        .cancel         (cancel),
        .done           (done),
        .done_cancelled (done_cancelled),
        .busy           (busy),
        .av_address     (av_address),
        .av_chipselect  (av_chipselect),
        .av_write_n     (av_write_n),
        .av_writedata   (av_writedata),
        .av_waitrequest (av_waitrequest),
        .av_irq         (av_irq)
    );

    // Write monitor: samples after the bench has driven its inputs for the cycle,
    // so the values seen are those the DUT presents at the next rising edge.
    always begin
        @(negedge clk);
        #2;
        if (reset_n && av_chipselect && !av_write_n && !av_waitrequest) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_write observed=%0d:%04h expected=none", av_address, av_writedata);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                assert ({av_address, av_writedata} === {mon_e.addr, mon_e.data}) else begin
                    bad++;
                    $error("FAIL write observed=%0d:%04h expected=%0d:%04h",
                           av_address, av_writedata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input logic [31:0] per);
        push(3'd1, 16'h0008);
        push(3'd2, per[15:0]);
        push(3'd3, per[31:16]);
        push(3'd1, 16'h0005);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req = '0; cancel = '0; av_irq = 1'b0; av_waitrequest = 1'b0;
        nstep();
        reset_n = 1'b1;
        nstep();
    endtask

    // Services requester idx already requesting; add_req is raised once its START write is seen.
    task automatic serve(input int idx, input logic [31:0] per, input int irq_delay,
                         input logic [N-1:0] add_req);
        int n;
        push_seq(per);
        push(3'd0, 16'h0000);
        n = 0;
        while (!(av_chipselect && av_address == 3'd1 && av_writedata == 16'h0005) && n < 40) begin
            nstep();
            n++;
        end
        chk("start_wait", 32'(n < 40), 1);
        req = req | add_req;
        repeat (irq_delay) nstep();
        av_irq = 1'b1;
        nstep();
        av_irq = 1'b0;
        chk("clr_write", {av_chipselect, av_write_n, av_address}, {1'b1, 1'b0, 3'd0});
        nstep();
        chk("done_owner", 32'(done), 32'(1) << idx);
        chk("done_cancelled", 32'(done_cancelled), 0);
        req[idx] = 1'b0;
        nstep();
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_after_done", 32'(busy), 0);
    endtask

    logic [2:0]  t1_addr [4];
    logic [15:0] t1_data [4];
    logic        any_cs;

    initial begin
        reset_n = 1'b0;
        req = '0; req_period = '0; cancel = '0;
        av_waitrequest = 1'b0; av_irq = 1'b0;
        #1;
        // reset values
        chk("rst_cs", 32'(av_chipselect), 0);
        chk("rst_write_n", 32'(av_write_n), 1);
        chk("rst_addr_data", {13'd0, av_address, av_writedata}, 0);
        chk("rst_done", {27'd0, done, done_cancelled}, 0);
        chk("rst_busy", 32'(busy), 0);
        nstep();
        reset_n = 1'b1;
        nstep();

        // 1: single request, cycle-exact write sequence
        t1_addr = '{3'd1, 3'd2, 3'd3, 3'd1};
        t1_data = '{16'h0008, 16'd100, 16'h0000, 16'h0005};
        req_period[63:32] = 32'd100;
        push_seq(32'd100);
        push(3'd0, 16'h0000);
        req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            nstep();
            chk("t1_bus", {av_chipselect, av_write_n, av_address, av_writedata},
                {1'b1, 1'b0, t1_addr[k], t1_data[k]});
        end
        any_cs = 1'b0;
        for (int k = 0; k < 101; k++) begin
            nstep();
            any_cs = any_cs | av_chipselect;
        end
        chk("t1_quiet_wait", 32'(any_cs), 0);
        chk("t1_busy_wait", 32'(busy), 1);
        av_irq = 1'b1;
        nstep();
        av_irq = 1'b0;
        chk("t1_clr", {av_chipselect, av_write_n, av_address, av_writedata}, {1'b1, 1'b0, 3'd0, 16'h0});
        nstep();
        chk("t1_done", 32'(done), 32'b0010);
        req = '0;
        nstep();
        chk("t1_done_end", 32'(done), 0);

        // 2: round robin from pointer 0
        apply_reset();
        req_period[31:0]   = 32'd20;
        req_period[63:32]  = 32'd30;
        req_period[95:64]  = 32'd50;
        req_period[127:96] = 32'd40;
        req = 4'b1011;
        serve(0, 32'd20, 3, 4'b0000);
        serve(1, 32'd30, 3, 4'b0000);
        serve(3, 32'd40, 5, 4'b0101);
        serve(0, 32'd20, 2, 4'b0000);
        serve(2, 32'd50, 2, 4'b0000);

        // 3: period split across halves, then period 0
        req_period[95:64] = 32'h0001_0000;
        req = 4'b0100;
        serve(2, 32'h0001_0000, 2, 4'b0000);
        req_period[127:96] = 32'd0;
        req = 4'b1000;
        nstep();
        chk("t3_zero_done", 32'(done), 32'b1000);
        chk("t3_zero_no_cs", 32'(av_chipselect), 0);
        req = '0;
        nstep();
        chk("t3_zero_done_end", 32'(done), 0);

        // 4: waitrequest held 3 cycles in W_PL (pointer is 0 after owner 3)
        req_period[31:0] = 32'd7;
        push_seq(32'd7);
        push(3'd0, 16'h0000);
        req = 4'b0001;
        nstep();
        chk("t4_stop", {av_address, av_writedata}, {3'd1, 16'h0008});
        nstep();
        chk("t4_pl_0", {av_chipselect, av_write_n, av_address, av_writedata}, {1'b1, 1'b0, 3'd2, 16'd7});
        av_waitrequest = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            nstep();
            chk("t4_pl_hold", {av_chipselect, av_write_n, av_address, av_writedata}, {1'b1, 1'b0, 3'd2, 16'd7});
        end
        av_waitrequest = 1'b0;
        nstep();
        chk("t4_ph_next", {av_address, av_writedata}, {3'd3, 16'd0});
        nstep();
        chk("t4_start", {av_address, av_writedata}, {3'd1, 16'h0005});
        nstep();
        av_irq = 1'b1;
        nstep();
        av_irq = 1'b0;
        nstep();
        chk("t4_done", 32'(done), 32'b0001);
        req = '0;
        nstep();

        // 6: reset during W_PH
        req_period[95:64] = 32'd9;
        push(3'd1, 16'h0008);
        push(3'd2, 16'd9);
        req = 4'b0100;
        nstep();
        nstep();
        nstep();
        chk("t6_in_ph", {av_chipselect, av_address}, {1'b1, 3'd3});
        reset_n = 1'b0;
        #1;
        chk("t6_rst_bus", {av_chipselect, av_write_n, av_address, av_writedata}, {1'b0, 1'b1, 3'd0, 16'd0});
        chk("t6_rst_status", {done, done_cancelled, busy}, 0);
        req = '0;
        nstep();
        chk("t6_sb_drained", exp_q.size(), 0);
        reset_n = 1'b1;
        nstep();
        req = 4'b0100;
        serve(2, 32'd9, 2, 4'b0000);

`ifdef TMR_SEQ_CANCEL_EN
        // 5: cancel, and cancel coinciding with irq (pointer is 3 after owner 2)
        req_period[63:32] = 32'd60;
        push_seq(32'd60);
        push(3'd1, 16'h0008);
        push(3'd0, 16'h0000);
        req = 4'b0010;
        repeat (4) nstep();
        repeat (10) nstep();
        cancel = 4'b0010;
        nstep();
        cancel = '0;
        chk("t5_cancel_stop", {av_chipselect, av_address, av_writedata}, {1'b1, 3'd1, 16'h0008});
        nstep();
        chk("t5_cancel_clr", {av_chipselect, av_address}, {1'b1, 3'd0});
        nstep();
        chk("t5_cancel_done", {done, done_cancelled}, {4'b0010, 1'b1});
        req = '0;
        nstep();
        req_period[31:0] = 32'd60;
        push_seq(32'd60);
        push(3'd0, 16'h0000);
        req = 4'b0001;
        repeat (4) nstep();
        repeat (3) nstep();
        cancel = 4'b0001;
        av_irq = 1'b1;
        nstep();
        cancel = '0;
        av_irq = 1'b0;
        chk("t5_race_clr", {av_chipselect, av_address}, {1'b1, 3'd0});
        nstep();
        chk("t5_race_done", {done, done_cancelled}, {4'b0001, 1'b0});
        req = '0;
        nstep();
`endif

        nstep();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
